// File: rtl/compute_seq_pkg.sv
// Shared definitions for the compute sequencer: state encoding, opcodes, default depth.
// No logic of its own; zero latency.
// No flow control; consumers apply their own handshakes.
package compute_seq_pkg;

  localparam int PROG_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Opcode lives in the top nibble of every 16-bit instruction word.
  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage

// File: rtl/compute_sequencer_prog_buffer.sv
// Program storage: DEPTH x 16-bit entries, one synchronous write port, one combinational read port.
// Write lands on the next rising edge; read is same-cycle.
// No backpressure; the writer guarantees the address is in range.
import compute_seq_pkg::*;

module prog_buffer #(
  parameter int DEPTH = PROG_DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH];

  // Entries are deliberately left unreset; they hold garbage until loaded.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/compute_sequencer.sv
// Loads a byte-streamed program, then issues one instruction every two cycles to a compute unit and captures results.
// Issue is combinational from state (ISSUE cycle); results captured in WAIT appear on out_* one cycle later.
// Loading stalls via in_ready when not idle, full, or start/clear pending; the compute unit cannot stall issue.
import compute_seq_pkg::*;

module compute_sequencer #(
  parameter int PROG_DEPTH = PROG_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  input  logic        clear,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] issue_instr,
  output logic        issue_en,
  input  logic        res_valid,
  input  logic [7:0]  res_data,
  input  logic [3:0]  res_reg_id,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [3:0]  out_reg_id
);

  localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int CW = $clog2(PROG_DEPTH + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] pc_q;
  logic [CW-1:0] pc_inc;
  logic          half_q;
  logic [7:0]    hi_q;
  logic [15:0]   instr_q;
  logic [15:0]   rd_data;
  logic          accept;
  logic          wr_en;
  logic          is_halt;

  prog_buffer #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_prog (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data ({hi_q, in_byte}),
    .rd_addr (pc_q),
    .rd_data (rd_data)
  );

  assign in_ready = (state_q == ST_IDLE) && (count_q < CW'(PROG_DEPTH)) && !start && !clear;
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && half_q;
  assign is_halt  = (opcode_of(rd_data) == OP_HALT);
  assign pc_inc   = CW'(pc_q) + CW'(1);
  assign busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done     = (state_q == ST_DONE);
  // Outside an issue cycle the bus keeps showing the last issued word.
  assign issue_instr = issue_en ? rd_data : instr_q;

  // State register; reset drops the run instantly so issue_en falls with rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and issue strobe; clear beats start, HALT and abort end the run without issuing.
  always_comb begin
    state_d  = state_q;
    issue_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!clear && start && (count_q != '0)) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (abort || is_halt) begin
          state_d = ST_DONE;
        end else begin
          issue_en = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort || !(pc_inc < count_q)) state_d = ST_DONE;
        else                               state_d = ST_ISSUE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: byte pairing and fill count in IDLE, issue hold, result capture and pc advance in WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      half_q     <= 1'b0;
      hi_q       <= 8'h00;
      pc_q       <= '0;
      instr_q    <= 16'h0000;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_reg_id <= 4'h0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear) begin
            count_q <= '0;
            half_q  <= 1'b0;
          end else if (start && (count_q != '0)) begin
            half_q <= 1'b0;
            pc_q   <= '0;
          end else if (accept) begin
            if (!half_q) begin
              hi_q   <= in_byte;
              half_q <= 1'b1;
            end else begin
              half_q  <= 1'b0;
              count_q <= count_q + CW'(1);
            end
          end
        end
        ST_ISSUE: begin
          if (issue_en) instr_q <= rd_data;
        end
        ST_WAIT: begin
          if (res_valid) begin
            out_valid  <= 1'b1;
            out_data   <= res_data;
            out_reg_id <= res_reg_id;
          end
          pc_q <= pc_inc[AW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_sequencer.sv
// Bench for compute_sequencer: directed scenarios, a behavioural reference checked every cycle,
// a small compute-unit model answering issued instructions, and literal expectations per scenario.
module tb_compute_sequencer;
  import compute_seq_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, issue_en, out_valid;
  logic [15:0] issue_instr;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data = 8'h00;
  logic [3:0]  res_reg_id = 4'h0;
  logic [7:0]  out_data;
  logic [3:0]  out_reg_id;

  compute_sequencer #(.PROG_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .clear(clear), .abort(abort), .busy(busy), .done(done),
    .issue_instr(issue_instr), .issue_en(issue_en), .res_valid(res_valid),
    .res_data(res_data), .res_reg_id(res_reg_id), .out_valid(out_valid),
    .out_data(out_data), .out_reg_id(out_reg_id)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0, issue_cnt = 0, done_cnt = 0, done_cyc = 0;
  logic [15:0] ilog_w[$];
  int          ilog_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event log of handshakes, issues and done pulses.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (in_valid && in_ready) acc_cnt++;
      if (issue_en) begin
        issue_cnt++;
        ilog_w.push_back(issue_instr);
        ilog_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Compute-unit model: answers an issued instruction during the following cycle.
  logic [7:0]  cu_r[16];
  logic        cu_take;
  logic [15:0] cu_word;
  initial begin
    foreach (cu_r[i]) cu_r[i] = 8'h00;
    forever begin
      @(negedge clk);
      cu_take = issue_en;
      cu_word = issue_instr;
      @(posedge clk);
      #1;
      res_valid = 1'b0;
      if (cu_take) begin
        logic [3:0] d, a, b;
        logic       v;
        d = cu_word[11:8];
        a = cu_word[7:4];
        b = cu_word[3:0];
        v = 1'b1;
        case (cu_word[15:12])
          OP_LOAD: cu_r[d] = cu_word[7:0];
          OP_ADD:  cu_r[d] = cu_r[a] + cu_r[b];
          OP_SUB:  cu_r[d] = cu_r[a] - cu_r[b];
          OP_AND:  cu_r[d] = cu_r[a] & cu_r[b];
          OP_OR:   cu_r[d] = cu_r[a] | cu_r[b];
          OP_XOR:  cu_r[d] = cu_r[a] ^ cu_r[b];
          OP_NOT:  cu_r[d] = ~cu_r[a];
          OP_NOP, OP_HALT: v = 1'b0;
          default: v = 1'b0;
        endcase
        res_valid  = v;
        res_data   = cu_r[d];
        res_reg_id = d;
      end
    end
  end

  // Reference: program image, fill level, and a run timeline where even offsets are issue slots.
  logic [15:0] m_prog[DEPTH];
  int          m_cnt = 0, m_off = 0;
  bit          m_half = 0, m_run = 0, m_done = 0, m_outv = 0;
  logic [7:0]  m_hi = 8'h00, m_od = 8'h00;
  logic [3:0]  m_or = 4'h0;
  logic [15:0] m_last = 16'h0000;

  initial forever begin
    logic        e_rdy, e_en, issuing;
    logic [15:0] w, e_instr;
    int          idx;
    @(negedge clk);
    if (!rstn) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_issue_en", issue_en, 0);
      check("rst_issue_instr", issue_instr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_reg_id", out_reg_id, 0);
      check("rst_in_ready", in_ready, !start && !clear);
      m_cnt = 0; m_half = 0; m_run = 0; m_done = 0; m_outv = 0;
      m_od = 8'h00; m_or = 4'h0; m_last = 16'h0000;
    end else begin
      e_rdy   = !m_run && !m_done && (m_cnt < DEPTH) && !start && !clear;
      issuing = m_run && (m_off % 2 == 0);
      idx     = m_off / 2;
      w       = issuing ? m_prog[idx] : 16'h0000;
      e_en    = issuing && (w[15:12] != 4'hF) && !abort;
      e_instr = e_en ? w : m_last;
      check("busy", busy, m_run);
      check("done", done, m_done);
      check("issue_en", issue_en, e_en);
      check("issue_instr", issue_instr, e_instr);
      check("in_ready", in_ready, e_rdy);
      check("out_valid", out_valid, m_outv);
      check("out_data", out_data, m_od);
      check("out_reg_id", out_reg_id, m_or);
      m_outv = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (issuing) begin
          if (!e_en) begin
            m_run = 0; m_done = 1;
          end else begin
            m_last = w; m_off++;
          end
        end else begin
          if (res_valid) begin
            m_outv = 1; m_od = res_data; m_or = res_reg_id;
          end
          if (abort || (idx + 1 >= m_cnt)) begin
            m_run = 0; m_done = 1;
          end else begin
            m_off++;
          end
        end
      end else if (clear) begin
        m_cnt = 0; m_half = 0;
      end else if (start && m_cnt > 0) begin
        m_run = 1; m_off = 0; m_half = 0;
      end else if (in_valid && e_rdy) begin
        if (!m_half) begin
          m_hi = in_byte; m_half = 1;
        end else begin
          m_prog[m_cnt] = {m_hi, in_byte}; m_cnt++; m_half = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic run_prog(input string name);
    int n = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (!done && n < 60) begin
      tick;
      n++;
    end
    check({name, "_done_seen"}, done, 1);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t, d0, a0, i0;

    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_issue_en", issue_en, 0);
    check("init_issue_instr", issue_instr, 0);
    check("init_out_valid", out_valid, 0);
    check("init_out_data", out_data, 0);
    check("init_out_reg_id", out_reg_id, 0);
    check("init_in_ready", in_ready, 1);
    tick;

    // LOAD r3,5 ; LOAD r4,7 ; ADD r5=r3+r4
    ilog_w.delete(); ilog_c.delete();
    push(8'h13); push(8'h05); push(8'h14); push(8'h07); push(8'h25); push(8'h34);
    run_prog("s1");
    check("s1_n_issued", ilog_w.size(), 3);
    if (ilog_w.size() == 3) begin
      t = ilog_c[0];
      check("s1_w0", ilog_w[0], 16'h1305);
      check("s1_w1", ilog_w[1], 16'h1407);
      check("s1_w2", ilog_w[2], 16'h2534);
      check("s1_t1", ilog_c[1], t + 2);
      check("s1_t2", ilog_c[2], t + 4);
      check("s1_done_t", done_cyc, t + 6);
    end
    check("s1_out_data", out_data, 8'h0C);
    check("s1_out_reg", out_reg_id, 4'h5);

    // HALT in the middle stops the run before the third word.
    pulse_clear;
    ilog_w.delete(); ilog_c.delete();
    d0 = done_cnt;
    push(8'h13); push(8'h01); push(8'hF0); push(8'h00); push(8'h14); push(8'h02);
    run_prog("s3");
    check("s3_n_issued", ilog_w.size(), 1);
    if (ilog_w.size() >= 1) check("s3_w0", ilog_w[0], 16'h1301);
    check("s3_done_cnt", done_cnt - d0, 1);
    check("s3_out_data", out_data, 8'h01);

    // Abort during the first WAIT.
    pulse_clear;
    i0 = issue_cnt;
    push(8'h13); push(8'h11); push(8'h14); push(8'h22); push(8'h25); push(8'h34);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    tick;
    check("s4_busy_after", busy, 0);
    check("s4_issued", issue_cnt - i0, 1);
    check("s4_out_data", out_data, 8'h11);
    check("s4_out_reg", out_reg_id, 4'h3);

    // start on an empty buffer; start+clear together.
    pulse_clear;
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("s5_empty_busy", busy, 0);
    repeat (3) tick;
    push(8'h13); push(8'h01); push(8'h14); push(8'h02);
    start = 1'b1;
    clear = 1'b1;
    tick;
    start = 1'b0;
    clear = 1'b0;
    check("s5_sc_busy", busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("s5_cleared_busy", busy, 0);
    tick;
    check("s5_no_done", done_cnt - d0, 0);
    check("s5_in_ready", in_ready, 1);

    // Overfill: 17 bytes into an 8-word buffer.
    pulse_clear;
    a0 = acc_cnt;
    i0 = issue_cnt;
    for (int i = 0; i < 17; i++) push(8'(i));
    check("s2_accepted", acc_cnt - a0, 16);
    check("s2_full_rdy", in_ready, 0);
    run_prog("s2");
    check("s2_issued", issue_cnt - i0, 8);

    // Reset during WAIT.
    pulse_clear;
    push(8'h13); push(8'h05); push(8'h14); push(8'h07);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("s6_in_wait", busy, 1);
    #1 rstn = 1'b0;
    #1;
    check("s6_busy", busy, 0);
    check("s6_issue_en", issue_en, 0);
    check("s6_done", done, 0);
    check("s6_instr", issue_instr, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("s6_in_ready", in_ready, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("s6_empty_busy", busy, 0);

    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
